// File: rtl/sched_dispatch_v2.sv
// Task-program dispatcher: walks program memory, gates each task on core
// collisions and fences, then streams mask, r0 and instructions to the cores.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   prog_we/prog_addr/wdata    program load port (IDLE/DONE only)
//   start                      begin walk at address 0 (IDLE/DONE only)
//   core_busy                  per-core busy flags, sampled in WAIT
//   msg_valid/ready/data/type  registered valid/ready message bus
//   busy, done, err_overrun    status; stall_cycles counts blocked WAITs
module sched_dispatch_v2 #(
  parameter int DEPTH     = 1024,
  parameter int WORD_W    = 16,
  parameter int SEG_WORDS = 16,
  parameter int CORE_NUM  = 16,
  parameter int IFCNT_W   = 6,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [WORD_W-1:0]   prog_wdata,
  input  logic                start,
  input  logic [CORE_NUM-1:0] core_busy,
  output logic                msg_valid,
  input  logic                msg_ready,
  output logic [WORD_W-1:0]   msg_data,
  output logic [1:0]          msg_type,
  output logic                busy,
  output logic                done,
  output logic                err_overrun,
  output logic [31:0]         stall_cycles
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int EXT_W = ADDR_W + IFCNT_W + 2;
  localparam int REM_W = IFCNT_W + $clog2(SEG_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MASK,
    S_R0,
    S_INSTR,
    S_DONE
  } state_t;

  state_t state;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    rd_addr;
  logic [REM_W-1:0]    rem;
  logic [IFCNT_W-1:0]  if_cnt_q;
  logic                acq_q;
  logic                rel_q;
  logic [CORE_NUM-1:0] mask_q;
  logic [CORE_NUM-1:0] r0_q;
  logic                acq_pending;
  logic [CORE_NUM-1:0] acq_mask;

  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_DONE))
      mem[prog_addr] <= prog_wdata;
  end

  // Header decode straight off the array at ptr.
  logic [ADDR_W-1:0]   pa;
  logic [IFCNT_W-1:0]  h_if;
  logic [1:0]          h_fence;
  logic                h_end;
  logic [CORE_NUM-1:0] h_mask;
  logic [CORE_NUM-1:0] h_r0;
  logic                h_acq;
  logic                h_rel;

  assign pa      = ptr[ADDR_W-1:0];
  assign h_if    = mem[pa][IFCNT_W-1:0];
  assign h_fence = mem[pa][IFCNT_W+1:IFCNT_W];
  assign h_end   = mem[pa][IFCNT_W+2];
  assign h_mask  = mem[pa + ADDR_W'(1)][CORE_NUM-1:0];
  assign h_r0    = mem[pa + ADDR_W'(2)][CORE_NUM-1:0];

  always_comb begin
    h_acq = 1'b0;
    h_rel = 1'b0;
    unique case (h_fence)
      2'b01:   h_acq = 1'b1;
      2'b10:   h_rel = 1'b1;
      default: ;
    endcase
  end

  // Task length check is done wide so a huge if_cnt cannot wrap.
  logic [EXT_W-1:0] task_len;
  logic [EXT_W-1:0] task_end;
  logic             at_end;
  logic             overrun;

  assign task_len = (EXT_W'(h_if) + EXT_W'(1)) * EXT_W'(SEG_WORDS);
  assign task_end = EXT_W'(ptr) + task_len;
  assign at_end   = (ptr == PTR_W'(DEPTH));
  assign overrun  = (task_end > EXT_W'(DEPTH));

  logic wait_ok;
  assign wait_ok = ((mask_q & core_busy) == '0)
                && (!rel_q || core_busy == '0)
                && (!acq_pending || (acq_mask & core_busy) == '0);

  logic [PTR_W-1:0] seg;
  logic [PTR_W-1:0] rd_first;
  logic [PTR_W-1:0] rd_nxt;

  assign seg      = PTR_W'(SEG_WORDS);
  assign rd_first = ptr + seg;
  assign rd_nxt   = rd_addr + PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      rd_addr      <= '0;
      rem          <= '0;
      if_cnt_q     <= '0;
      acq_q        <= 1'b0;
      rel_q        <= 1'b0;
      mask_q       <= '0;
      r0_q         <= '0;
      acq_pending  <= 1'b0;
      acq_mask     <= '0;
      msg_valid    <= 1'b0;
      msg_data     <= '0;
      msg_type     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overrun  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ptr          <= '0;
            done         <= 1'b0;
            err_overrun  <= 1'b0;
            acq_pending  <= 1'b0;
            stall_cycles <= '0;
            busy         <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if_cnt_q <= h_if;
          acq_q    <= h_acq;
          rel_q    <= h_rel;
          mask_q   <= h_mask;
          r0_q     <= h_r0;
          if (at_end || h_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (overrun) begin
            err_overrun <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else if (h_mask == '0) begin
            ptr <= ptr + PTR_W'(task_len);
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_ok) begin
            acq_pending <= 1'b0;
            msg_valid   <= 1'b1;
            msg_type    <= 2'b01;
            msg_data    <= WORD_W'(mask_q);
            state       <= S_MASK;
          end else if (stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
          end
        end
        S_MASK: begin
          if (msg_ready) begin
            if (acq_q) begin
              acq_pending <= 1'b1;
              acq_mask    <= mask_q;
            end
            msg_type <= 2'b10;
            msg_data <= WORD_W'(r0_q);
            state    <= S_R0;
          end
        end
        S_R0: begin
          if (msg_ready) begin
            if (if_cnt_q == '0) begin
              ptr       <= ptr + seg;
              msg_valid <= 1'b0;
              msg_type  <= '0;
              msg_data  <= '0;
              state     <= S_FETCH;
            end else begin
              rd_addr  <= rd_first;
              rem      <= REM_W'(if_cnt_q) * REM_W'(SEG_WORDS);
              msg_type <= 2'b11;
              msg_data <= mem[rd_first[ADDR_W-1:0]];
              state    <= S_INSTR;
            end
          end
        end
        S_INSTR: begin
          if (msg_ready) begin
            if (rem == REM_W'(1)) begin
              ptr       <= rd_nxt;
              msg_valid <= 1'b0;
              msg_type  <= '0;
              msg_data  <= '0;
              state     <= S_FETCH;
            end else begin
              rd_addr  <= rd_nxt;
              rem      <= rem - REM_W'(1);
              msg_data <= mem[rd_nxt[ADDR_W-1:0]];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sched_dispatch_v2.md
Name: sched_dispatch_v2

Overview:
- Parametrised successor to the frame scheduler.
- Walks a task program held in an internal register-array program memory and streams each task to the cores over a valid/ready message bus: core mask, then r0 init vector, then instruction words.
- Before dispatching a task it enforces core-collision avoidance and acquire/release fences.
- Adds a serial program-load port, backpressure, end-of-program and overrun detection, task skipping, and a stall counter.

Parameters:
DEPTH, 1024, program memory words (power of 2); ADDR_W = $clog2(DEPTH)
WORD_W, 16, program word and message width
SEG_WORDS, 16, words per segment (header or instruction segment)
CORE_NUM, 16, core count; must be <= WORD_W
IFCNT_W, 6, width of header instruction-segment count

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  program write address
prog_wdata  in  WORD_W  program write data
start  in  1  start pulse; program walk begins at address 0
core_busy  in  CORE_NUM  per-core busy flags (1 = executing)
msg_valid  out  1  message valid
msg_ready  in  1  consumer accepts message
msg_data  out  WORD_W  message payload
msg_type  out  2  01 mask, 10 r0 vector, 11 instruction
busy  out  1  high in any state except IDLE/DONE
done  out  1  high in DONE
err_overrun  out  1  sticky: task ran past end of memory
stall_cycles  out  32  count of WAIT cycles that did not exit

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; ptr, acq_pending, acq_mask and stall_cycles cleared. Memory is not reset.
- Program writes: accepted when prog_we=1 and the block is in IDLE/DONE; ignored otherwise.
- Task layout at ptr:
  - Header segment of SEG_WORDS words.
  - word0: [IFCNT_W-1:0] if_cnt; [IFCNT_W+1:IFCNT_W] fence (00 none, 01 ACQ, 10 REL, 11 treated as none); [IFCNT_W+2] END.
  - word1: core mask, low CORE_NUM bits.
  - word2: r0 init vector, low CORE_NUM bits, zero-extended on output.
  - Remaining header words are skipped.
  - if_cnt instruction segments of SEG_WORDS words follow the header.
- start: takes effect only in IDLE/DONE. Sets ptr=0, clears done, err_overrun, acq_pending and stall_cycles, then enters FETCH. Ignored otherwise.
- FETCH (1 cycle): latch header fields. Exit conditions, in priority order:
  - ptr == DEPTH or END=1 -> DONE.
  - ptr + (1+if_cnt)*SEG_WORDS > DEPTH (computed ADDR_W+IFCNT_W+2 bits wide) -> set err_overrun, go DONE.
  - mask == 0 -> ptr += (1+if_cnt)*SEG_WORDS, stay in FETCH (task skipped, no messages).
  - Otherwise -> WAIT.
- WAIT: exits to SEND_MASK when all three conditions hold:
  - (mask & core_busy) == 0;
  - fence != REL, or core_busy == 0;
  - acq_pending == 0, or (acq_mask & core_busy) == 0.
  Each WAIT cycle that does not exit increments stall_cycles (saturating at all-ones).
- Pending ACQ clears on exit from WAIT.
- SEND_MASK: msg_valid=1, type 01, data=mask. On handshake: if fence == ACQ, set acq_pending=1 and acq_mask=mask. Then go to SEND_R0.
- SEND_R0: type 10, data = r0 vector. On handshake:
  - if_cnt == 0 -> ptr += SEG_WORDS, go FETCH.
  - else -> SEND_INSTR, with read address = ptr+SEG_WORDS and remaining = if_cnt*SEG_WORDS.
- SEND_INSTR: type 11, data = mem[read address]. Each handshake advances the address and decrements remaining. The handshake on the last word sets ptr = address+1 and goes to FETCH.
- Handshake rules:
  - Transfer occurs when msg_valid & msg_ready.
  - While msg_valid=1 and msg_ready=0, msg_data and msg_type are held stable.
  - msg_valid drops the cycle after the last handshake of a task.
  - msg_valid never rises outside the SEND states.
  - Outputs are registered.
- Latency:
  - start sampled at cycle 0 -> FETCH cycle 1, WAIT cycle 2, mask valid cycle 3 (with no busy conflict).
  - Between tasks: last instruction handshake at cycle t -> next mask valid at t+3.
  - With msg_ready held high, one word per cycle.
- core_busy is sampled only in WAIT. Changes during SEND states have no effect.
- DONE: holds until start. Asynchronous reset in any state returns to IDLE immediately.

Test Plan:
- Single task: if_cnt=1, fence none, mask=0x0003, r0=0x0001; core_busy=0; msg_ready=1 -> 18 messages: 0x0003/01, 0x0001/10, 16 instruction words/11. Mask appears at cycle 3. done is asserted after END header.
- Collision: mask=0x00F0, core_busy=0x0010 for 5 cycles then 0 -> WAIT holds 5 cycles, stall_cycles=5, then mask message.
- REL fence: task2 REL, mask=0x0100, core_busy=0x0001 -> no dispatch until core_busy=0. ACQ: task1 ACQ mask=0x0003, task2 mask=0x0C00, core_busy=0x0001 -> task2 waits until bit0 clears.
- Backpressure: msg_ready toggles 1,0,0,1 during SEND_INSTR -> no word lost or duplicated; data stable while stalled.
- Boundaries:
  - mask=0 task -> skipped with no messages.
  - Header at DEPTH-16 with if_cnt=1 -> err_overrun=1, DONE, no messages.
  - start while busy -> ignored.
  - reset low mid-SEND_INSTR -> msg_valid=0 immediately, state IDLE.
